// File: rtl/transformer_pkg.sv
// ----------------------------------------------------------------------------
// transformer_pkg
// Shared types for the transformer encoder datapath and its stream adapter.
//   TF_SEQ / TF_EMB / TF_DATA_W : default frame geometry and element width
//   elem_t                      : signed encoder element
//   adapter_state_e             : encoder_stream_adapter FSM states
// ----------------------------------------------------------------------------
package transformer_pkg;

    localparam int TF_SEQ    = 4;
    localparam int TF_EMB    = 8;
    localparam int TF_DATA_W = 16;

    typedef logic signed [TF_DATA_W-1:0] elem_t;

    typedef enum logic [2:0] {
        LOAD,
        DISCARD,
        KICK,
        WAIT,
        DRAIN
    } adapter_state_e;

endpackage

// File: rtl/encoder_stream_adapter.sv
// ----------------------------------------------------------------------------
// encoder_stream_adapter
// Stream front end for transformer_encoder_block. Collects a token-major input
// stream into the encoder's in_seq array, pulses start, waits for done,
// snapshots out_seq and replays it on a token-major output stream.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input stream (one element per beat)
//   enc_in_seq               : registered array driven to encoder in_seq
//   enc_start                : one-cycle start pulse to the encoder
//   enc_done                 : encoder done level
//   enc_out_seq              : encoder result array
//   m_valid/m_ready/m_data/m_last : output stream (one element per beat)
//   err_short                : pulse, frame ended before SEQ*EMB beats
//   err_long                 : pulse, frame ran past SEQ*EMB beats
//   busy                     : high whenever the adapter is not in LOAD
// ----------------------------------------------------------------------------
module encoder_stream_adapter
    import transformer_pkg::*;
#(
    parameter int SEQ    = TF_SEQ,
    parameter int EMB    = TF_EMB,
    parameter int DATA_W = TF_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_W-1:0]                    s_data,
    input  logic                                 s_last,
    output logic [SEQ-1:0][EMB-1:0][DATA_W-1:0]  enc_in_seq,
    output logic                                 enc_start,
    input  logic                                 enc_done,
    input  logic [SEQ-1:0][EMB-1:0][DATA_W-1:0]  enc_out_seq,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_W-1:0]                    m_data,
    output logic                                 m_last,
    output logic                                 err_short,
    output logic                                 err_long,
    output logic                                 busy
);

    localparam int                TOTAL    = SEQ * EMB;
    localparam int                IDX_W    = $clog2(TOTAL);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TOTAL - 1);

    // Arrays are held flat, slot k = t*EMB + e; this matches the packed
    // [SEQ][EMB] layout bit for bit, so token-major beat k lands in slot k.
    adapter_state_e                  state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [TOTAL-1:0][DATA_W-1:0]    in_q, in_d;
    logic [TOTAL-1:0][DATA_W-1:0]    snap_q, snap_d;
    logic                            s_ready_q, s_ready_d;
    logic                            enc_start_q, enc_start_d;
    logic                            m_valid_q, m_valid_d;
    logic [DATA_W-1:0]               m_data_q, m_data_d;
    logic                            m_last_q, m_last_d;
    logic                            err_short_q, err_short_d;
    logic                            err_long_q, err_long_d;
    logic                            busy_q, busy_d;

    logic                            s_hs;
    logic                            m_hs;

    assign s_hs = s_valid & s_ready_q;
    assign m_hs = m_valid_q & m_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        in_d        = in_q;
        snap_d      = snap_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        case (state_q)
            LOAD: begin
                if (s_hs) begin
                    in_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = KICK;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = DISCARD;
                        end
                    end else if (s_last) begin
                        // Early end of frame: clear every slot after this beat
                        // so stale data from the previous frame never reaches
                        // the encoder.
                        for (int k = 0; k < TOTAL; k++) begin
                            if (k > int'(idx_q)) begin
                                in_d[IDX_W'(k)] = '0;
                            end
                        end
                        idx_d       = '0;
                        err_short_d = 1'b1;
                        state_d     = KICK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (s_hs && s_last) begin
                    state_d = KICK;
                end
            end
            KICK: begin
                // enc_done may still be high from the previous frame; it is
                // only looked at from WAIT onwards.
                state_d = WAIT;
            end
            WAIT: begin
                if (enc_done) begin
                    snap_d  = enc_out_seq;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // All stream/control outputs are registered copies of what the next
        // state implies, so they line up with state_q one cycle later.
        s_ready_d   = (state_d == LOAD) || (state_d == DISCARD);
        enc_start_d = (state_d == KICK);
        busy_d      = (state_d != LOAD);
        m_valid_d   = (state_d == DRAIN);
        // snap_d rather than snap_q: on the WAIT->DRAIN edge the first beat
        // comes straight from the array being captured.
        m_data_d    = m_valid_d ? snap_d[idx_d] : '0;
        m_last_d    = m_valid_d && (idx_d == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: both arrays are reset because enc_in_seq is a visible
            // output with a defined reset value and a reset must never let a
            // stale snapshot leak onto the output stream.
            state_q     <= LOAD;
            idx_q       <= '0;
            in_q        <= '0;
            snap_q      <= '0;
            s_ready_q   <= 1'b1;
            enc_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_q        <= in_d;
            snap_q      <= snap_d;
            s_ready_q   <= s_ready_d;
            enc_start_q <= enc_start_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            busy_q      <= busy_d;
        end
    end

    assign enc_in_seq = in_q;
    assign s_ready    = s_ready_q;
    assign enc_start  = enc_start_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign busy       = busy_q;

endmodule

// File: doc/encoder_stream_adapter.md
# encoder_stream_adapter

Stream-side front end for `transformer_encoder_block`. It assembles a token-major valid/ready input stream into the encoder's `SEQ`×`EMB` `in_seq` array and issues a one-cycle `start`. It waits for `done`, snapshots `out_seq`, and serializes the snapshot onto a valid/ready output stream. This makes it the writer and reader at the far end of the encoder's array/start/done interface.

## Interface
- `SEQ`, 4, tokens per frame
- `EMB`, 8, elements per token
- `DATA_W`, 16, signed element width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  adapter accepts input beat
- `s_data`  in  `DATA_W`  signed input element
- `s_last`  in  1  final beat of input frame
- `enc_in_seq`  out  [`SEQ`][`EMB`]×`DATA_W`  registered array to encoder `in_seq`
- `enc_start`  out  1  one-cycle start pulse to encoder
- `enc_done`  in  1  encoder done, level
- `enc_out_seq`  in  [`SEQ`][`EMB`]×`DATA_W`  encoder result array
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accepts
- `m_data`  out  `DATA_W`  output element
- `m_last`  out  1  final beat of output frame
- `err_short`  out  1  one-cycle pulse: `s_last` arrived before `SEQ*EMB` beats
- `err_long`  out  1  one-cycle pulse: frame exceeded `SEQ*EMB` beats
- `busy`  out  1  high in any state other than LOAD

## Operation
- Element order on both streams is token-major with element index fastest: beat k maps to t = k / `EMB`, e = k % `EMB`.
- Beat index counter width is `$clog2(SEQ*EMB)`. Arithmetic is plain index increment; data passes through unmodified.
- States: LOAD, DISCARD, KICK, WAIT, DRAIN.
- LOAD: `s_ready`=1. Each handshake writes `s_data` into `enc_in_seq[t][e]` and increments the index.
  - Beat `SEQ*EMB-1` with `s_last`=1 → KICK.
  - Beat `SEQ*EMB-1` with `s_last`=0 → pulse `err_long`, go to DISCARD.
  - `s_last`=1 on an earlier beat → store that beat, zero-fill all remaining slots in the same cycle, pulse `err_short`, go to KICK.
- DISCARD: `s_ready`=1. Beats are accepted and dropped. Handshake with `s_last`=1 → KICK.
- KICK: `s_ready`=0, `enc_start`=1 for exactly this one cycle → WAIT. `enc_done` is ignored in KICK.
- WAIT: `s_ready`=0. On the first cycle `enc_done` is sampled high:
  - copy all of `enc_out_seq` into the internal snapshot buffer;
  - reset the index;
  - go to DRAIN.
- DRAIN: `m_valid`=1 and `m_data` = snapshot[t][e].
  - `m_last`=1 when index = `SEQ*EMB-1`.
  - The index advances only on `m_valid & m_ready`.
  - The last handshake clears the index and returns to LOAD.
- `enc_in_seq` holds stable from KICK through the end of DRAIN. It is rewritten only by LOAD handshakes of the next frame.
- `m_data`/`m_last` hold stable while `m_valid & !m_ready`.

## Timing
- Reset values:
  - state LOAD, index 0, `enc_in_seq` and snapshot all zero;
  - `s_ready`=1, `enc_start`=0, `m_valid`=0, `m_data`=0, `m_last`=0;
  - `err_short`=0, `err_long`=0, `busy`=0.
- Assertion of `rst` during any state aborts the frame asynchronously. No partial output beats follow reset.
- `enc_start` is asserted the cycle after the final accepted input beat.
- `m_valid` first rises the cycle after `enc_done` is sampled high in WAIT.
- With `m_ready` held at 1, DRAIN takes exactly `SEQ*EMB` cycles. `s_ready` rises the cycle after the `m_last` handshake.
- `s_ready` is a registered function of state. `s_ready` and `m_valid` are never high in the same cycle.
- Error pulses are registered and appear the cycle after the offending beat.

## Structure
- Add to `transformer_pkg`:
  - `typedef logic signed [DATA_W-1:0]` element type;
  - adapter state enum (`LOAD`, `DISCARD`, `KICK`, `WAIT`, `DRAIN`).
- Single module, no sub-module. The input array, snapshot buffer and FSM are one flat process group.

## Test plan
- Nominal frame:
  - stimulus: 32 beats, value (t+1)*(e+1), `s_last` on beat 31; stub encoder asserts `enc_done` 5 cycles after `start` with `out_seq` = `in_seq`+1;
  - response: `enc_start` is a single pulse the cycle after beat 31, `enc_in_seq[3][7]`=32, and the output stream is 32 beats, (t+1)*(e+1)+1, `m_last` only on the 32nd.
- Output backpressure:
  - stimulus: `m_ready` toggles 1,0,0,1 repeating;
  - response: every beat is held stable while stalled, no duplicates, no drops, 32 beats total.
- Short frame:
  - stimulus: `s_last` on beat 9;
  - response: one `err_short` pulse, slots 10..31 = 0, `enc_start` fires, output beats 10..31 = 1 under the stub.
- Long frame:
  - stimulus: 35 beats, `s_last` on beat 34;
  - response: one `err_long` pulse the cycle after beat 31, beats 32..34 dropped, `enc_start` the cycle after beat 34.
- Reset mid-operation:
  - stimulus: `rst` asserted in WAIT and again in DRAIN after 3 output beats;
  - response: outputs return immediately to reset values, `s_ready`=1 after release, and the next nominal frame completes correctly.
- Stale done:
  - stimulus: `enc_done` held high from the prior frame through KICK;
  - response: `start` is still pulsed, and the snapshot is taken in the first WAIT cycle.
